regs_wb_arbiter: RTL

- Sequences the register file's single synchronous write port between three requesters: ALU writeback, load-store-unit (LSU) load return, and the debug port.
- Contains a one-entry skid buffer that absorbs an ALU result displaced by a colliding LSU write.
- Contains a small FSM that runs debug register reads and writes while the core is held.
- Sits between the writeback stage and the register file; its outputs drive the file's write port and one debug read address.

---
 rtl/regs_wb_arbiter_pkg.sv | 22 ++
 rtl/regs_skid_buf.sv | 29 ++
 rtl/regs_wb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/regs_wb_arbiter_pkg.sv
// Shared widths, debug FSM encodings and writeback bundle for the
// register-file write-port arbiter.
package regs_wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_DRD  = 2'd1,
    DBG_DWR  = 2'd2,
    DBG_ACK  = 2'd3
  } dbg_state_e;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regs_skid_buf.sv
// One-entry skid register holding a displaced ALU result.
// Ports: load (fill/reload from d), drain (clear), valid/q contents.
module regs_skid_buf
  import regs_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    drain,
  input  wb_req_t d,
  output logic    valid,
  output wb_req_t q
);

  // load wins over drain: a drain with a
  // simultaneous accept is a reload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter: LSU > skid > ALU > debug write,
// plus a debug read/write FSM. Ports: ALU/LSU/DBG requesters, REGS_*
// write port, DBG_rdaddr/DBG_rddata read port, PEND_* skid contents.
module regs_wb_arbiter
  import regs_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ALU_valid,
  output logic            ALU_ready,
  input  logic [AW-1:0]   ALU_addr,
  input  logic [XLEN-1:0] ALU_data,
  input  logic            LSU_valid,
  input  logic [AW-1:0]   LSU_addr,
  input  logic [XLEN-1:0] LSU_data,
  input  logic            HOLD,
  input  logic            DBG_req,
  input  logic            DBG_we,
  input  logic [AW-1:0]   DBG_addr,
  input  logic [XLEN-1:0] DBG_wdata,
  output logic            DBG_ack,
  output logic [XLEN-1:0] DBG_rdata,
  output logic [AW-1:0]   DBG_rdaddr,
  input  logic [XLEN-1:0] DBG_rddata,
  output logic            REGS_wen,
  output logic [AW-1:0]   REGS_wraddr,
  output logic [XLEN-1:0] REGS_wrdata,
  output logic            PEND_valid,
  output logic [AW-1:0]   PEND_addr,
  output logic [XLEN-1:0] PEND_data
);

  dbg_state_e state, state_nx;
  logic [XLEN-1:0] rdata_q;

  logic    pend_v;
  wb_req_t pend_q;
  wb_req_t alu_req;
  wb_req_t gnt;
  logic    gnt_v;
  logic    alu_acc;
  logic    dbg_gnt;
  logic    skid_load;
  logic    skid_drain;

  assign alu_req   = '{addr: ALU_addr, data: ALU_data};
  assign ALU_ready = !pend_v || !LSU_valid;
  assign alu_acc   = ALU_valid && ALU_ready;

  assign dbg_gnt = (state == DBG_DWR) && !LSU_valid
                && !pend_v && !ALU_valid;

  // ALU goes to the skid whenever it cannot
  // write directly this cycle
  assign skid_load  = alu_acc && (LSU_valid || pend_v);
  assign skid_drain = pend_v && !LSU_valid;

  regs_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .drain (skid_drain),
    .d     (alu_req),
    .valid (pend_v),
    .q     (pend_q)
  );

  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    unique case (1'b1)
      LSU_valid: begin
        gnt_v = 1'b1;
        gnt   = '{addr: LSU_addr, data: LSU_data};
      end
      (!LSU_valid && pend_v): begin
        gnt_v = 1'b1;
        gnt   = pend_q;
      end
      (!LSU_valid && !pend_v && ALU_valid): begin
        gnt_v = 1'b1;
        gnt   = alu_req;
      end
      dbg_gnt: begin
        gnt_v = 1'b1;
        gnt   = '{addr: DBG_addr, data: DBG_wdata};
      end
      default: begin
        gnt_v = 1'b0;
      end
    endcase
  end

  // x0 writes are consumed but never reach the file
  assign REGS_wen    = rst_n && gnt_v
                    && (gnt.addr != ZERO_REG);
  assign REGS_wraddr = gnt.addr;
  assign REGS_wrdata = gnt.data;

  assign PEND_valid = rst_n && pend_v;
  assign PEND_addr  = rst_n ? pend_q.addr : '0;
  assign PEND_data  = rst_n ? pend_q.data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= DBG_IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == DBG_DRD) begin
        rdata_q <= DBG_rddata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      DBG_IDLE: begin
        if (DBG_req && HOLD) begin
          state_nx = DBG_we ? DBG_DWR : DBG_DRD;
        end
      end
      DBG_DRD: state_nx = DBG_ACK;
      DBG_DWR: begin
        if (dbg_gnt) begin
          state_nx = DBG_ACK;
        end
      end
      DBG_ACK: state_nx = DBG_IDLE;
      default: state_nx = DBG_IDLE;
    endcase
  end

  assign DBG_ack    = rst_n && (state == DBG_ACK);
  assign DBG_rdata  = rst_n ? rdata_q : '0;
  assign DBG_rdaddr = (state == DBG_DRD) ? DBG_addr : '0;

endmodule
